// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end.
// Holds the nop encoding, the default reset PC, the word size and the queue entry type.
// Every fetch-side module imports this package.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned WORD_BYTES       = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Purpose : small synchronous in-order FIFO (fetch entries or PC tags), with a clear that flushes it.
// Latency : a pushed entry is visible at head_o after the push edge; count_o updates on the same edge.
// Backpres: the caller must not push while full unless it also pops; the pop frees the slot first.
// Ports   : push_i/push_dat_i write, pop_i retires the head, clear_i empties (overrides push/pop),
//           head_o is the oldest entry, full_o/empty_o/count_o report occupancy.
module fetch_queue
    import mips_pkg::*;
#(
    parameter type         T     = fetch_entry_t,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW   = $clog2(DEPTH) + 1,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  T              push_dat_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output T              head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_dat_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (do_pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Overflow means the upstream issue throttle is broken.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !pop_i && !clear_i));

endmodule

// File: rtl/fetch_unit.sv
// Purpose : MIPS instruction-fetch front end; owns the PC, fetches over valid/ready, queues {instr, PC+4}.
// Latency : request accepted at edge N, response captured at N+1, if_valid_o high after N+1.
// Backpres: stall_i holds the head; issue is throttled so in-flight plus queued never exceeds QDEPTH.
// Ports   : redirect_i/redirect_pc_i flush and refetch; imem_req_* issue words; imem_resp_* return
//           them in order; if_* present the queue head to decode; fetch_pc_o is the next-request PC.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned       QDEPTH   = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [ADDR_W-1:0] imem_req_addr_o,
    input  logic              imem_resp_valid_i,
    input  logic [31:0]       imem_resp_data_i,
    output logic              if_valid_o,
    output logic [31:0]       if_instr_o,
    output logic [ADDR_W-1:0] if_pc_plus4_o,
    output logic [ADDR_W-1:0] fetch_pc_o
);

    localparam int unsigned       CW       = $clog2(QDEPTH) + 1;
    localparam logic [CW:0]       CAP      = (CW + 1)'(QDEPTH);
    localparam logic [ADDR_W-1:0] WORD_INC = ADDR_W'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN    = ~ADDR_W'(WORD_BYTES - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     qcount;
    logic [CW:0]       occupancy;
    logic              req_fire;
    logic              resp_keep;
    logic              pop_head;
    logic [ADDR_W-1:0] tag_head;
    logic              tag_full, tag_empty;
    fetch_entry_t      q_head, q_push;
    logic              q_full, q_empty;

    // Issue throttle: outstanding requests plus buffered entries never exceed QDEPTH,
    // which is what keeps the queue from overflowing. Dropped responses still count.
    assign occupancy        = {1'b0, inflight} + {1'b0, qcount};
    assign imem_req_valid_o = rst_ni && !redirect_i && (occupancy < CAP);
    assign imem_req_addr_o  = pc_q;
    assign fetch_pc_o       = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // A response is kept only if no flush is pending for it and none is happening now.
    assign resp_keep = imem_resp_valid_i && !redirect_i && (drop_q == '0);
    assign pop_head  = !q_empty && !stall_i && !redirect_i;
    assign q_push    = '{instr: imem_resp_data_i, pc_plus4: tag_head};

    // PC+4 tags in request order; its occupancy is the in-flight count. Tags of
    // responses that are later dropped are popped the same way as kept ones.
    fetch_queue #(
        .T     (logic [ADDR_W-1:0]),
        .DEPTH (QDEPTH)
    ) u_tag_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (req_fire),
        .push_dat_i (pc_q + WORD_INC),
        .pop_i      (imem_resp_valid_i),
        .clear_i    (1'b0),
        .head_o     (tag_head),
        .full_o     (tag_full),
        .empty_o    (tag_empty),
        .count_o    (inflight)
    );

    fetch_queue #(
        .T     (fetch_entry_t),
        .DEPTH (QDEPTH)
    ) u_instr_q (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (resp_keep),
        .push_dat_i (q_push),
        .pop_i      (pop_head),
        .clear_i    (redirect_i),
        .head_o     (q_head),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .count_o    (qcount)
    );

    assign if_valid_o    = !q_empty;
    assign if_instr_o    = q_empty ? NOP_INSTR : q_head.instr;
    assign if_pc_plus4_o = q_empty ? '0 : q_head.pc_plus4;

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_i) begin
            // Everything still outstanding becomes stale, except a response landing now,
            // which is discarded directly.
            pc_d   = redirect_pc_i & ALIGN;
            drop_d = inflight - CW'(imem_resp_valid_i);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + WORD_INC;
            end
            if (imem_resp_valid_i && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    // In-order memory may only answer outstanding requests.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(imem_resp_valid_i && tag_empty));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(req_fire && tag_full && !imem_resp_valid_i));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(resp_keep && q_full && !pop_head));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XORPAT   = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } mem_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        req_valid;
    logic        ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] pc4;
    logic [31:0] fetch_pc;

    exp_t        sb[$];
    mem_t        pend[$];
    logic [31:0] exp_pc;
    int          cyc;
    int          lat;
    int          n_pass  = 0;
    int          n_total = 0;

    fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC),
        .QDEPTH   (2)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .stall_i           (stall),
        .redirect_i        (redirect),
        .redirect_pc_i     (rpc),
        .imem_req_valid_o  (req_valid),
        .imem_req_ready_i  (ready),
        .imem_req_addr_o   (req_addr),
        .imem_resp_valid_i (resp_valid),
        .imem_resp_data_i  (resp_data),
        .if_valid_o        (if_valid),
        .if_instr_o        (if_instr),
        .if_pc_plus4_o     (pc4),
        .fetch_pc_o        (fetch_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Mid-cycle model update: scoreboard pops on consume, pushes on handshake,
    // flushes on redirect; the memory model schedules the response.
    task automatic sample();
        exp_t e;
        int   due;
        chk("fetch_pc", fetch_pc, exp_pc);
        if (redirect) begin
            chk("no_req_on_redirect", 32'(req_valid), 32'd0);
            sb.delete();
            exp_pc = rpc & ~32'h3;
        end else begin
            if (if_valid && !stall) begin
                if (sb.size() == 0) begin
                    chk("spurious_output", 32'(if_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("instr", if_instr, e.instr);
                    chk("pc_plus4", pc4, e.pc4);
                end
            end
            if (req_valid && ready) begin
                chk("req_addr", req_addr, exp_pc);
                sb.push_back('{exp_pc ^ XORPAT, exp_pc + 32'd4});
                due = cyc + lat;
                if (pend.size() > 0 && pend[$].due >= due) due = pend[$].due + 1;
                pend.push_back('{due, req_addr ^ XORPAT});
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    task automatic step();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = pend[0].data;
            pend.delete(0);
        end else begin
            resp_valid = 1'b0;
            resp_data  = $urandom;
        end
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; rpc = '0; ready = 1'b1;
        resp_valid = 1'b0; resp_data = '0; lat = 1; cyc = 0; exp_pc = RESET_PC;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_pc_plus4", pc4, 32'h0);
        chk("rst_fetch_pc", fetch_pc, RESET_PC);

        // Release: first request at 0, first entry visible two cycles later
        rst_n = 1'b1;
        #1;
        chk("c0_if_valid", 32'(if_valid), 32'd0);
        chk("c0_req_valid", 32'(req_valid), 32'd1);
        chk("c0_req_addr", req_addr, 32'h0);
        step();
        chk("c1_if_valid", 32'(if_valid), 32'd0);
        step();
        chk("c2_if_valid", 32'(if_valid), 32'd1);
        chk("c2_if_instr", if_instr, 32'hA5A5_0000);
        chk("c2_pc_plus4", pc4, 32'h4);
        repeat (10) step();

        // Stall for 5 cycles: queue fills to 2, issue stops, head holds
        stall = 1'b1;
        repeat (3) step();
        chk("stall_head_instr_3", if_instr, sb[0].instr);
        repeat (2) step();
        chk("stall_req_valid", 32'(req_valid), 32'd0);
        chk("stall_if_valid", 32'(if_valid), 32'd1);
        chk("stall_buffered", 32'(sb.size()), 32'd2);
        chk("stall_head_instr_5", if_instr, sb[0].instr);
        chk("stall_head_pc4_5", pc4, sb[0].pc4);
        stall = 1'b0;
        repeat (8) step();

        // Redirect with two requests in flight, latency 3
        lat = 3;
        for (int i = 0; i < 30 && pend.size() != 2; i++) step();
        chk("redir_two_inflight", 32'(pend.size()), 32'd2);
        redirect = 1'b1; rpc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        #1;
        chk("redir_next_addr", req_addr, 32'h0000_0100);
        for (int i = 0; i < 20 && !if_valid; i++) step();
        chk("redir_if_valid", 32'(if_valid), 32'd1);
        chk("redir_pc_plus4", pc4, 32'h0000_0104);
        chk("redir_instr", if_instr, 32'hA5A5_0100);
        repeat (6) step();

        // Redirect coinciding with a response while stalled
        lat = 1;
        for (int i = 0; i < 20 && !(pend.size() > 0 && pend[0].due <= cyc); i++) step();
        chk("coinc_resp_due", 32'(pend.size() > 0 && pend[0].due <= cyc), 32'd1);
        stall = 1'b1; redirect = 1'b1; rpc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        #1;
        chk("coinc_if_valid", 32'(if_valid), 32'd0);
        chk("coinc_if_instr", if_instr, 32'h0);
        chk("coinc_pc_plus4", pc4, 32'h0);
        stall = 1'b0;
        repeat (6) step();

        // Ready low for 4 cycles: address and PC stay put
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("nrdy_addr", req_addr, exp_pc);
        end
        chk("nrdy_req_valid", 32'(req_valid), 32'd1);
        ready = 1'b1;
        repeat (6) step();

        // PC wrap at the top of the address space
        redirect = 1'b1; rpc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        #1;
        chk("wrap_addr", req_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 20 && !if_valid; i++) step();
        chk("wrap_if_valid", 32'(if_valid), 32'd1);
        chk("wrap_pc_plus4", pc4, 32'h0);
        chk("wrap_instr", if_instr, 32'h5A5A_FFFC);
        repeat (6) step();

        // Reset mid-stream with a full queue
        stall = 1'b1;
        for (int i = 0; i < 20 && !(sb.size() == 2 && pend.size() == 0); i++) step();
        chk("full_before_reset", 32'(sb.size()), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_if_valid", 32'(if_valid), 32'd0);
        chk("arst_fetch_pc", fetch_pc, RESET_PC);
        chk("arst_req_valid", 32'(req_valid), 32'd0);
        sb.delete(); pend.delete(); exp_pc = RESET_PC;
        resp_valid = 1'b0; stall = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        #1;
        chk("rs_req_addr", req_addr, RESET_PC);
        step();
        step();
        chk("rs_if_valid", 32'(if_valid), 32'd1);
        chk("rs_pc_plus4", pc4, 32'h4);
        chk("rs_instr", if_instr, 32'hA5A5_0000);
        repeat (6) step();

        // Drain: every issued request must come out
        ready = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
